// File: rtl/chip8_core_sequencer.sv
// ---------------------------------------------------------------------------
// chip8_core_sequencer
//
// Control core of the CHIP-8 CPU. Divides the system clock into CPU-step and
// 60 Hz-style timer ticks, runs the two-byte instruction fetch sequence, and
// owns the program counter, the return stack and the delay/sound timers.
// Instruction decode/execute lives in an external execute unit, which sees the
// opcode during EXEC and answers with a PC operation plus exec_done.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   mem_rd, mem_addr        memory read strobe/address (data returns next cycle)
//   mem_data                read data from memory
//   opcode, opcode_valid    fetched instruction, valid (and stable) in EXEC
//   exec_done               execute unit finished, sampled only in EXEC
//   pc_op, pc_target        0 NEXT, 1 SKIP, 2 JUMP, 3 CALL, 4 RET, 5 HOLD
//   dt_we, st_we,           load delay / sound timer with timer_wdata
//   timer_wdata
//   delay_timer, sound_on   delay timer value, sound timer non-zero
//   pc, sp                  program counter, stack entries in use
//   tick_missed             one-cycle pulse when a CPU tick arrives while busy
//   fault                   sticky stack overflow/underflow (core halts)
// ---------------------------------------------------------------------------
module chip8_core_sequencer #(
  parameter int                CLK_HZ      = 50_000_000,
  parameter int                CPU_HZ      = 540,
  parameter int                TIMER_HZ    = 60,
  parameter int                ADDR_W      = 12,
  parameter int                STACK_DEPTH = 16,
  parameter logic [ADDR_W-1:0] PC_RESET    = 'h200,
  localparam int               SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [15:0]       opcode,
  output logic              opcode_valid,
  input  logic              exec_done,
  input  logic [2:0]        pc_op,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic              dt_we,
  input  logic              st_we,
  input  logic [7:0]        timer_wdata,
  output logic [7:0]        delay_timer,
  output logic              sound_on,
  output logic [ADDR_W-1:0] pc,
  output logic [SP_W-1:0]   sp,
  output logic              tick_missed,
  output logic              fault
);

  localparam int CPU_DIV = CLK_HZ / CPU_HZ;
  localparam int TMR_DIV = CLK_HZ / TIMER_HZ;
  localparam int CPU_CW  = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam int TMR_CW  = (TMR_DIV > 1) ? $clog2(TMR_DIV) : 1;
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [CPU_CW-1:0] CPU_RELOAD = CPU_CW'(CPU_DIV - 1);
  localparam logic [TMR_CW-1:0] TMR_RELOAD = TMR_CW'(TMR_DIV - 1);
  localparam logic [SP_W-1:0]   SP_FULL    = SP_W'(STACK_DEPTH);

  localparam logic [2:0] OP_SKIP = 3'd1;
  localparam logic [2:0] OP_JUMP = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HOLD = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_HI = 3'd1,
    FETCH_LO = 3'd2,
    LATCH    = 3'd3,
    EXEC     = 3'd4,
    HALT     = 3'd5
  } state_t;

  // Write has priority over the tick; a timer at zero stays at zero.
  function automatic logic [7:0] timer_next(input logic [7:0] cur,
                                            input logic       we,
                                            input logic [7:0] wdata,
                                            input logic       tick);
    if (we) return wdata;
    if (tick && (cur != 8'd0)) return cur - 8'd1;
    return cur;
  endfunction

  state_t              state, state_nxt;
  logic [CPU_CW-1:0]   cpu_cnt;
  logic [TMR_CW-1:0]   tmr_cnt;
  logic                cpu_tick, tmr_tick;
  logic [7:0]          sound_timer;
  logic [ADDR_W-1:0]   stack [STACK_DEPTH];
  logic [ADDR_W-1:0]   pc_nxt, pc_inc2;
  logic [SP_W-1:0]     sp_nxt;
  logic [IDX_W-1:0]    push_idx, pop_idx;
  logic                push, fault_set;

  assign cpu_tick    = (cpu_cnt == '0);
  assign tmr_tick    = (tmr_cnt == '0);
  assign tick_missed = cpu_tick && (state != IDLE);
  assign sound_on    = (sound_timer != 8'd0);
  assign pc_inc2     = pc + ADDR_W'(2);
  assign push_idx    = IDX_W'(sp);
  assign pop_idx     = IDX_W'(sp - SP_W'(1));

  // Free-running dividers; each tick lasts one cycle, period is exactly DIV.
  always_ff @(posedge clk) begin
    if (reset || cpu_tick) cpu_cnt <= CPU_RELOAD;
    else                   cpu_cnt <= cpu_cnt - CPU_CW'(1);
    if (reset || tmr_tick) tmr_cnt <= TMR_RELOAD;
    else                   tmr_cnt <= tmr_cnt - TMR_CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    mem_rd       = 1'b0;
    mem_addr     = pc;
    opcode_valid = 1'b0;
    pc_nxt       = pc;
    sp_nxt       = sp;
    push         = 1'b0;
    fault_set    = 1'b0;
    case (state)
      IDLE:     if (cpu_tick) state_nxt = FETCH_HI;
      FETCH_HI: begin
        mem_rd    = 1'b1;
        state_nxt = FETCH_LO;
      end
      FETCH_LO: begin
        mem_rd    = 1'b1;
        mem_addr  = pc + ADDR_W'(1);
        state_nxt = LATCH;
      end
      LATCH:    state_nxt = EXEC;
      EXEC: begin
        opcode_valid = 1'b1;
        if (exec_done) begin
          state_nxt = IDLE;
          case (pc_op)
            OP_SKIP: pc_nxt = pc + ADDR_W'(4);
            OP_JUMP: pc_nxt = pc_target;
            OP_CALL: begin
              if (sp == SP_FULL) begin
                fault_set = 1'b1;
                state_nxt = HALT;
              end else begin
                push   = 1'b1;
                sp_nxt = sp + SP_W'(1);
                pc_nxt = pc_target;
              end
            end
            OP_RET: begin
              if (sp == '0) begin
                fault_set = 1'b1;
                state_nxt = HALT;
              end else begin
                sp_nxt = sp - SP_W'(1);
                pc_nxt = stack[pop_idx];
              end
            end
            OP_HOLD: pc_nxt = pc;
            default: pc_nxt = pc_inc2;  // NEXT and the unused codes 6/7
          endcase
        end
      end
      HALT:     state_nxt = HALT;
      default:  state_nxt = IDLE;
    endcase
  end

  // High byte arrives during FETCH_LO, low byte during LATCH, so the opcode
  // is complete on the first EXEC cycle and untouched until the next fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= PC_RESET;
      sp          <= '0;
      opcode      <= '0;
      fault       <= 1'b0;
      delay_timer <= 8'd0;
      sound_timer <= 8'd0;
    end else begin
      pc          <= pc_nxt;
      sp          <= sp_nxt;
      if (fault_set)         fault        <= 1'b1;
      if (state == FETCH_LO) opcode[15:8] <= mem_data;
      if (state == LATCH)    opcode[7:0]  <= mem_data;
      delay_timer <= timer_next(delay_timer, dt_we, timer_wdata, tmr_tick);
      sound_timer <= timer_next(sound_timer, st_we, timer_wdata, tmr_tick);
    end
  end

  // Return addresses are plain storage; sp alone defines which are live.
  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= pc_inc2;
  end

endmodule

// File: tb/tb_chip8_core_sequencer.sv
module tb_chip8_core_sequencer;

  localparam int ADDR_W = 12;
  localparam int SP_W   = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data = 8'd0;
  logic [15:0]       opcode;
  logic              opcode_valid;
  logic              exec_done = 1'b0;
  logic [2:0]        pc_op = 3'd0;
  logic [ADDR_W-1:0] pc_target = '0;
  logic              dt_we = 1'b0;
  logic              st_we = 1'b0;
  logic [7:0]        timer_wdata = 8'd0;
  logic [7:0]        delay_timer;
  logic              sound_on;
  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;
  logic              tick_missed;
  logic              fault;

  chip8_core_sequencer #(
    .CLK_HZ(100), .CPU_HZ(10), .TIMER_HZ(5),
    .ADDR_W(ADDR_W), .STACK_DEPTH(16), .PC_RESET(12'h200)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .opcode(opcode), .opcode_valid(opcode_valid),
    .exec_done(exec_done), .pc_op(pc_op), .pc_target(pc_target),
    .dt_we(dt_we), .st_we(st_we), .timer_wdata(timer_wdata),
    .delay_timer(delay_timer), .sound_on(sound_on),
    .pc(pc), .sp(sp), .tick_missed(tick_missed), .fault(fault)
  );

  always #5 clk = ~clk;

  // Memory: read data appears the cycle after the strobe.
  logic [7:0] mem [4096];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  // Cycle index since the last reset edge (cycle 0 = first cycle out of reset).
  int rc = 0;
  always @(posedge clk) rc <= reset ? 0 : rc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (rc=%0d)", name, act, exp, rc);
  endtask

  // ---------------- behavioural model ----------------
  // Works in terms of "cycles since tick was accepted" (m_phase) rather than
  // named states: 1,2 = the two memory reads, 3 = data settling, 4 = executing.
  bit          m_known = 0;
  bit          m_halt, m_fault;
  int          m_cyc, m_phase;
  logic [11:0] m_pc;
  logic [15:0] m_opcode;
  logic [7:0]  m_dt, m_st;
  logic [11:0] m_stack [$];

  always @(negedge clk) begin
    bit          tick, ttick, e_rd;
    logic [11:0] a1;
    tick  = (m_cyc % 10) == 9;
    ttick = (m_cyc % 20) == 19;
    a1    = m_pc + 12'd1;
    if (m_known) begin
      e_rd = !m_halt && (m_phase == 1 || m_phase == 2);
      check("m.mem_rd", mem_rd, e_rd);
      if (e_rd) check("m.mem_addr", mem_addr, (m_phase == 1) ? m_pc : a1);
      check("m.opcode_valid", opcode_valid, !m_halt && m_phase == 4);
      if (m_halt || m_phase != 3) check("m.opcode", opcode, m_opcode);
      check("m.pc", pc, m_pc);
      check("m.sp", sp, m_stack.size());
      check("m.delay", delay_timer, m_dt);
      check("m.sound_on", sound_on, m_st != 0);
      check("m.fault", fault, m_fault);
      check("m.tick_missed", tick_missed, tick && (m_halt || m_phase != 0));
    end
    if (reset) begin
      m_known = 1; m_halt = 0; m_fault = 0; m_cyc = 0; m_phase = 0;
      m_pc = 12'h200; m_opcode = 16'h0; m_dt = 0; m_st = 0;
      m_stack.delete();
    end else if (m_known) begin
      if (dt_we) m_dt = timer_wdata; else if (ttick && m_dt != 0) m_dt = m_dt - 8'd1;
      if (st_we) m_st = timer_wdata; else if (ttick && m_st != 0) m_st = m_st - 8'd1;
      if (!m_halt) begin
        case (m_phase)
          0: if (tick) m_phase = 1;
          1: m_phase = 2;
          2: m_phase = 3;
          3: begin m_opcode = {mem[m_pc], mem[a1]}; m_phase = 4; end
          default: if (exec_done) begin
            m_phase = 0;
            case (pc_op)
              3'd1: m_pc = m_pc + 12'd4;
              3'd2: m_pc = pc_target;
              3'd3: if (m_stack.size() == 16) begin m_fault = 1; m_halt = 1; end
                    else begin m_stack.push_back(m_pc + 12'd2); m_pc = pc_target; end
              3'd4: if (m_stack.size() == 0) begin m_fault = 1; m_halt = 1; end
                    else m_pc = m_stack.pop_back();
              3'd5: ;
              default: m_pc = m_pc + 12'd2;
            endcase
          end
        endcase
      end
      m_cyc++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic at_cycle(input int k);  // negedge of cycle k
    @(negedge clk);
    while (rc < k) @(negedge clk);
  endtask

  task automatic drive_at(input int k);  // just after the edge that starts cycle k
    @(posedge clk); #1;
    while (rc < k) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset;
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int miss;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
    mem[12'h300] = 8'h00; mem[12'h301] = 8'hEE;

    // 1: reset values, fetch timing, NEXT
    exec_done = 1'b1; pc_op = 3'd0;
    apply_reset;
    at_cycle(0);
    check("rst pc", pc, 12'h200);
    check("rst sp", sp, 0);
    check("rst opcode", opcode, 16'h0);
    check("rst mem_rd", mem_rd, 0);
    check("rst opcode_valid", opcode_valid, 0);
    check("rst delay", delay_timer, 0);
    check("rst sound_on", sound_on, 0);
    check("rst fault", fault, 0);
    check("rst tick_missed", tick_missed, 0);
    at_cycle(9);  check("t1 no fetch at tick", mem_rd, 0);
    at_cycle(10); check("t1 rd hi", mem_rd, 1); check("t1 addr hi", mem_addr, 12'h200);
    at_cycle(11); check("t1 rd lo", mem_rd, 1); check("t1 addr lo", mem_addr, 12'h201);
    at_cycle(12); check("t1 rd off", mem_rd, 0);
    at_cycle(13); check("t1 valid", opcode_valid, 1); check("t1 opcode", opcode, 16'h1234);
    at_cycle(14); check("t1 pc next", pc, 12'h202); check("t1 valid off", opcode_valid, 0);
    at_cycle(20); check("t1 2nd fetch rd", mem_rd, 1); check("t1 2nd fetch addr", mem_addr, 12'h202);

    // 2: delay and sound count down 3,2,1,0 on timer ticks (cycles 19,39,...)
    drive_at(21); dt_we = 1; st_we = 1; timer_wdata = 8'd3;
    drive_at(22); dt_we = 0; st_we = 0;
    at_cycle(22); check("t2 dt 3", delay_timer, 3); check("t2 snd 3", sound_on, 1);
    at_cycle(39); check("t2 dt before tick", delay_timer, 3);
    at_cycle(40); check("t2 dt 2", delay_timer, 2);
    at_cycle(60); check("t2 dt 1", delay_timer, 1); check("t2 snd 1", sound_on, 1);
    at_cycle(80); check("t2 dt 0", delay_timer, 0); check("t2 snd 0", sound_on, 0);
    at_cycle(100); check("t2 dt holds 0", delay_timer, 0);

    // 3: write wins over a simultaneous decrement
    drive_at(101); dt_we = 1; timer_wdata = 8'd5;
    drive_at(102); dt_we = 0;
    at_cycle(102); check("t3 dt 5", delay_timer, 5);
    drive_at(119); dt_we = 1; timer_wdata = 8'd7;
    drive_at(120); dt_we = 0;
    at_cycle(120); check("t3 write beats tick", delay_timer, 7);
    at_cycle(140); check("t3 dt 6", delay_timer, 6);

    // 4: CALL 0x300, RET, then RET underflow
    pc_op = 3'd3; pc_target = 12'h300;
    apply_reset;
    drive_at(14); pc_op = 3'd4;
    at_cycle(14); check("t4 call sp", sp, 1); check("t4 call pc", pc, 12'h300);
    at_cycle(20); check("t4 fetch target", mem_addr, 12'h300);
    at_cycle(24); check("t4 ret sp", sp, 0); check("t4 ret pc", pc, 12'h202);
    at_cycle(33); check("t4 no fault yet", fault, 0);
    at_cycle(34); check("t4 underflow fault", fault, 1); check("t4 underflow pc", pc, 12'h202);
    at_cycle(40); check("t4 halted no rd", mem_rd, 0);

    // 5: 17 nested CALLs overflow a 16-deep stack
    pc_op = 3'd3; pc_target = 12'h300;
    apply_reset;
    at_cycle(164); check("t5 sp full", sp, 16); check("t5 no fault", fault, 0);
    at_cycle(174); check("t5 overflow fault", fault, 1); check("t5 sp kept", sp, 16);
    check("t5 pc kept", pc, 12'h300);
    drive_at(175); dt_we = 1; timer_wdata = 8'd2;
    drive_at(176); dt_we = 0;
    at_cycle(180); check("t5 halt dt 1", delay_timer, 1); check("t5 halt no rd", mem_rd, 0);
    at_cycle(181); check("t5 halt no rd 2", mem_rd, 0);
    at_cycle(200); check("t5 halt dt 0", delay_timer, 0);

    // 6: long EXEC drops one tick, HOLD re-fetches, reset mid-fetch
    exec_done = 0; pc_op = 3'd0;
    apply_reset;
    miss = 0;
    for (int c = 13; c <= 27; c++) begin
      at_cycle(c);
      if (tick_missed) miss++;
    end
    check("t6 opcode stable", opcode, 16'h1234);
    check("t6 pc stable", pc, 12'h200);
    check("t6 tick_missed pulses", miss, 1);
    drive_at(28); exec_done = 1; pc_op = 3'd5;
    drive_at(29); exec_done = 0; dt_we = 1; timer_wdata = 8'd9;
    at_cycle(29); check("t6 hold pc", pc, 12'h200); check("t6 tick taken", tick_missed, 0);
    drive_at(30); dt_we = 0;
    at_cycle(30); check("t6 refetch rd", mem_rd, 1); check("t6 refetch addr", mem_addr, 12'h200);
    check("t6 dt 9", delay_timer, 9);
    drive_at(31); reset = 1;
    @(posedge clk); #1 reset = 0;
    at_cycle(0);
    check("t6 rst opcode", opcode, 16'h0);
    check("t6 rst dt", delay_timer, 0);
    check("t6 rst rd", mem_rd, 0);
    check("t6 rst pc", pc, 12'h200);
    at_cycle(14); check("t6 after rst valid", opcode_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
